// File: rtl/sd_audio_streamer_pkg.sv
// Shared constants, types and elaboration helpers for the SD audio streamer.
package sd_audio_pkg;

  localparam int unsigned BYTE_W             = 32'd8;
  localparam int unsigned SAMPLE_BITS_NARROW = 32'd8;
  localparam int unsigned SAMPLE_BITS_WIDE   = 32'd16;
  localparam int unsigned CHANNELS_MIN       = 32'd1;
  localparam int unsigned CHANNELS_MAX       = 32'd8;
  localparam int unsigned DEPTH_MIN          = 32'd2;

  typedef logic [BYTE_W-1:0] byte_t;

  // Bytes that make up one interleaved multi-channel frame.
  function automatic int unsigned bytes_per_frame(input int unsigned channels,
                                                  input int unsigned sample_bits);
    return (channels * sample_bits) / BYTE_W;
  endfunction

  // Clock cycles between sample ticks (truncating division).
  function automatic int unsigned tick_div(input int unsigned clk_hz,
                                           input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Width needed to hold a frame count from 0 to depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  function automatic bit sample_bits_legal(input int unsigned sample_bits);
    return (sample_bits == SAMPLE_BITS_NARROW) || (sample_bits == SAMPLE_BITS_WIDE);
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= DEPTH_MIN) && ((depth & (depth - 32'd1)) == 32'd0);
  endfunction

  function automatic bit channels_legal(input int unsigned channels);
    return (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX);
  endfunction

endpackage

// File: rtl/sd_audio_streamer_if.sv
// Byte request/return handshake between the streamer and the SD card reader.
interface sd_audio_streamer_if;
  import sd_audio_pkg::*;

  logic  byte_req;
  logic  byte_valid;
  byte_t byte_data;

  modport master (output byte_req, input byte_valid, input byte_data);
  modport slave  (input byte_req, output byte_valid, output byte_data);

endinterface

// File: rtl/sd_audio_streamer_frame_fifo.sv
// Synchronous frame FIFO with a flush input; head is the oldest stored frame.
module frame_fifo
  import sd_audio_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd32,
  parameter int unsigned DEPTH = 32'd64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [fill_width(DEPTH)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fill_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Gate push/pop against full/empty and flush; pop never sees a same-cycle push.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (!clear) begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
    end else begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Frame storage; contents are only read once a matching push has happened.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sd_audio_streamer.sv
// Streams SD card bytes into PCM frames, buffers them and emits one frame per sample tick.
module sd_audio_streamer
  import sd_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd100000000,
  parameter int unsigned SAMPLE_HZ   = 32'd32000,
  parameter int unsigned CHANNELS    = 32'd2,
  parameter int unsigned SAMPLE_BITS = 32'd16,
  parameter int unsigned DEPTH       = 32'd64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  sd_audio_streamer_if.master               reader,
  output logic [CHANNELS*SAMPLE_BITS-1:0]   sample_out,
  output logic                              sample_strobe,
  output logic [fill_width(DEPTH)-1:0]      fill_level,
  output logic                              underrun,
  input  logic                              clear_underrun
);

  localparam int unsigned BPF     = bytes_per_frame(CHANNELS, SAMPLE_BITS);
  localparam int unsigned DIV     = tick_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned FRAME_W = CHANNELS * SAMPLE_BITS;
  localparam int unsigned FILL_W  = fill_width(DEPTH);
  localparam int unsigned IDX_W   = (BPF > 32'd1) ? $clog2(BPF) : 32'd1;
  localparam int unsigned CNT_W   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPF - 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 32'd1);

  logic               outstanding_r;
  logic               byte_req_r;
  logic [IDX_W-1:0]   idx_r;
  logic [FRAME_W-1:0] frame_r;
  logic [CNT_W-1:0]   div_cnt_r;
  logic [FRAME_W-1:0] sample_out_r;
  logic               sample_strobe_r;
  logic               underrun_r;

  logic               req_s;
  logic               accept_s;
  logic               push_s;
  logic               tick_s;
  logic               pop_s;
  logic [FRAME_W-1:0] frame_next_s;
  logic [FRAME_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [FILL_W-1:0]  fifo_count_s;

  sd_audio_cfg_check #(
    .CLK_HZ      (CLK_HZ),
    .SAMPLE_HZ   (SAMPLE_HZ),
    .CHANNELS    (CHANNELS),
    .SAMPLE_BITS (SAMPLE_BITS),
    .DEPTH       (DEPTH)
  ) u_cfg_check ();

  // Per-cycle decisions: request, byte acceptance, frame completion and tick.
  always_comb begin
    req_s    = 1'b0;
    accept_s = reader.byte_valid & outstanding_r;
    push_s   = 1'b0;
    tick_s   = 1'b0;
    pop_s    = 1'b0;
    if (enable && !outstanding_r && !fifo_full_s) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    if (enable && accept_s && (idx_r == IDX_LAST)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (enable && (div_cnt_r == CNT_LAST)) begin
      tick_s = 1'b1;
      pop_s  = ~fifo_empty_s;
    end else begin
      tick_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  // Drop the returned byte into its little-endian slot of the frame under assembly.
  always_comb begin
    frame_next_s = frame_r;
    for (int b = 0; b < int'(BPF); b++) begin
      if (idx_r == IDX_W'(b)) begin
        frame_next_s[b*BYTE_W +: BYTE_W] = reader.byte_data;
      end else begin
        frame_next_s[b*BYTE_W +: BYTE_W] = frame_r[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Single-byte-in-flight tracking; a byte returned while disabled still retires the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_req_r    <= 1'b0;
      outstanding_r <= 1'b0;
    end else begin
      byte_req_r <= req_s;
      if (req_s) begin
        outstanding_r <= 1'b1;
      end else if (accept_s) begin
        outstanding_r <= 1'b0;
      end else begin
        outstanding_r <= outstanding_r;
      end
    end
  end

  // Frame assembler; disabling realigns the stream to byte 0 of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= {IDX_W{1'b0}};
      frame_r <= {FRAME_W{1'b0}};
    end else if (!enable) begin
      idx_r   <= {IDX_W{1'b0}};
      frame_r <= frame_r;
    end else if (accept_s) begin
      frame_r <= frame_next_s;
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1'b1);
      end
    end else begin
      idx_r   <= idx_r;
      frame_r <= frame_r;
    end
  end

  // Sample-rate divider, parked at zero while streaming is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else if (!enable) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else if (div_cnt_r == CNT_LAST) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1'b1);
    end
  end

  // Output stage: present the head frame on a tick, or flag an underrun if none is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out_r    <= {FRAME_W{1'b0}};
      sample_strobe_r <= 1'b0;
      underrun_r      <= 1'b0;
    end else begin
      sample_strobe_r <= pop_s;
      if (pop_s) begin
        sample_out_r <= head_s;
      end else begin
        sample_out_r <= sample_out_r;
      end
      if (tick_s && fifo_empty_s) begin
        underrun_r <= 1'b1;
      end else if (clear_underrun) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (~enable),
    .push      (push_s),
    .push_data (frame_next_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign reader.byte_req = byte_req_r;
  assign sample_out      = sample_out_r;
  assign sample_strobe   = sample_strobe_r;
  assign fill_level      = fifo_count_s;
  assign underrun        = underrun_r;

endmodule

// Rejects illegal parameter combinations at elaboration.
module sd_audio_cfg_check
  import sd_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd100000000,
  parameter int unsigned SAMPLE_HZ   = 32'd32000,
  parameter int unsigned CHANNELS    = 32'd2,
  parameter int unsigned SAMPLE_BITS = 32'd16,
  parameter int unsigned DEPTH       = 32'd64
) ();

  if (!sample_bits_legal(SAMPLE_BITS)) begin : g_bad_sample_bits
    $error("sd_audio_streamer: SAMPLE_BITS must be 8 or 16");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("sd_audio_streamer: DEPTH must be a power of two and at least 2");
  end
  if (!channels_legal(CHANNELS)) begin : g_bad_channels
    $error("sd_audio_streamer: CHANNELS must be 1..8");
  end
  if ((SAMPLE_HZ == 32'd0) || (tick_div(CLK_HZ, SAMPLE_HZ) == 32'd0)) begin : g_bad_rate
    $error("sd_audio_streamer: SAMPLE_HZ must be nonzero and not above CLK_HZ");
  end

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Directed bench: default stereo 16-bit streamer plus a small mono 8-bit, depth-4 instance.
module tb_sd_audio_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en1, en2, clr1, clr2;

  sd_audio_streamer_if bus1 ();
  sd_audio_streamer_if bus2 ();

  logic [31:0] sout1;
  logic        str1;
  logic [6:0]  fill1;
  logic        ur1;
  logic [7:0]  sout2;
  logic        str2;
  logic [2:0]  fill2;
  logic        ur2;

  sd_audio_streamer dut1 (
    .clk (clk), .rst_n (rst_n), .enable (en1), .reader (bus1),
    .sample_out (sout1), .sample_strobe (str1), .fill_level (fill1),
    .underrun (ur1), .clear_underrun (clr1)
  );

  sd_audio_streamer #(
    .CLK_HZ (32'd2000), .SAMPLE_HZ (32'd100), .CHANNELS (32'd1),
    .SAMPLE_BITS (32'd8), .DEPTH (32'd4)
  ) dut2 (
    .clk (clk), .rst_n (rst_n), .enable (en2), .reader (bus2),
    .sample_out (sout2), .sample_strobe (str2), .fill_level (fill2),
    .underrun (ur2), .clear_underrun (clr2)
  );

  // Reader 1: serves queued bytes, one per request, remembering an unanswered request.
  logic [7:0] q1 [$];
  bit         pend1;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend1 = 1'b0;
      bus1.byte_valid = 1'b0;
      bus1.byte_data  = 8'h00;
    end else begin
      bus1.byte_valid = 1'b0;
      if (bus1.byte_req) pend1 = 1'b1;
      if (pend1 && (q1.size() > 0)) begin
        bus1.byte_valid = 1'b1;
        bus1.byte_data  = q1.pop_front();
        pend1 = 1'b0;
      end
    end
  end

  // Reader 2: answers every request immediately with an incrementing byte.
  logic [7:0] next2;
  always @(negedge clk) begin
    if (!rst_n) begin
      next2 = 8'h10;
      bus2.byte_valid = 1'b0;
      bus2.byte_data  = 8'h00;
    end else if (bus2.byte_req) begin
      bus2.byte_valid = 1'b1;
      bus2.byte_data  = next2;
      next2 = next2 + 8'h01;
    end else begin
      bus2.byte_valid = 1'b0;
    end
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit sig_of(input int sel);
    case (sel)
      0:       return str1;
      1:       return str2;
      2:       return ur1;
      3:       return (fill1 != 7'd0);
      4:       return bus1.byte_req;
      5:       return (fill2 == 3'd4);
      6:       return (fill1 == 7'd4);
      default: return 1'b0;
    endcase
  endfunction

  // Step negedges until the selected condition holds or the budget runs out.
  task automatic wait_sig(input int sel, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(sel) && (n < limit));
  endtask

  int n;
  int reqs;

  initial begin
    rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample", sout1, 32'h0);
    chk("rst_strobe", 32'(str1), 32'd0);
    chk("rst_fill", 32'(fill1), 32'd0);
    chk("rst_underrun", 32'(ur1), 32'd0);
    chk("rst_req", 32'(bus1.byte_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full FIFO on the depth-4 instance.
    en2 = 1'b1;
    wait_sig(5, 40, n);
    chk("full_fill", 32'(fill2), 32'd4);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.byte_req) reqs++;
    end
    chk("full_noreq", 32'(reqs), 32'd0);
    wait_sig(1, 40, n);
    chk("s2_strobe", 32'(str2), 32'd1);
    chk("s2_first", 32'(sout2), 32'h10);
    reqs = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (bus2.byte_req) reqs++;
    end
    chk("full_onereq", 32'(reqs), 32'd1);
    chk("full_refill", 32'(fill2), 32'd4);
    wait_sig(1, 40, n);
    chk("s2_second", 32'(sout2), 32'h11);
    en2 = 1'b0;
    @(negedge clk);
    chk("s2_flush", 32'(fill2), 32'd0);

    // Frame assembly and tick spacing on the default instance.
    q1.push_back(8'h34); q1.push_back(8'h12); q1.push_back(8'h78); q1.push_back(8'h56);
    q1.push_back(8'h01); q1.push_back(8'h02); q1.push_back(8'h03); q1.push_back(8'h04);
    q1.push_back(8'hAA); q1.push_back(8'hBB); q1.push_back(8'hCC); q1.push_back(8'hDD);
    q1.push_back(8'h11); q1.push_back(8'h22); q1.push_back(8'h33); q1.push_back(8'h44);
    en1 = 1'b1;
    wait_sig(4, 2, n);
    chk("req_after_en", 32'(bus1.byte_req), 32'd1);
    wait_sig(3, 40, n);
    chk("fill_first", 32'(fill1), 32'd1);
    wait_sig(6, 60, n);
    chk("fill_four", 32'(fill1), 32'd4);
    wait_sig(0, 3200, n);
    chk("f1_strobe", 32'(str1), 32'd1);
    chk("f1_sample", sout1, 32'h56781234);
    @(negedge clk);
    chk("f1_pulse", 32'(str1), 32'd0);
    chk("f1_fill", 32'(fill1), 32'd3);
    wait_sig(0, 3200, n);
    chk("spacing_2", 32'(n + 1), 32'd3125);
    chk("f2_sample", sout1, 32'h04030201);
    wait_sig(0, 3200, n);
    chk("spacing_3", 32'(n), 32'd3125);
    chk("f3_sample", sout1, 32'hDDCCBBAA);
    wait_sig(0, 3200, n);
    chk("spacing_4", 32'(n), 32'd3125);
    chk("f4_sample", sout1, 32'h44332211);

    // Underrun with a silent reader, then clear and set-wins behaviour.
    wait_sig(2, 3200, n);
    chk("ur_set", 32'(ur1), 32'd1);
    chk("ur_time", 32'(n), 32'd3125);
    chk("ur_nostrobe", 32'(str1), 32'd0);
    chk("ur_hold", sout1, 32'h44332211);
    clr1 = 1'b1;
    @(negedge clk);
    chk("ur_clear", 32'(ur1), 32'd0);
    wait_sig(2, 3200, n);
    chk("ur_setwins", 32'(ur1), 32'd1);
    chk("ur_setwins_time", 32'(n), 32'd3124);
    @(negedge clk);
    chk("ur_clear_again", 32'(ur1), 32'd0);
    clr1 = 1'b0;

    // Disable mid-frame, return the outstanding byte, then restart aligned.
    q1.push_back(8'h77); q1.push_back(8'h88);
    repeat (8) @(negedge clk);
    chk("mid_fill", 32'(fill1), 32'd0);
    en1 = 1'b0;
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) q1.push_back(8'h99);
      if (bus1.byte_req) reqs++;
    end
    chk("dis_noreq", 32'(reqs), 32'd0);
    chk("dis_fill", 32'(fill1), 32'd0);
    chk("dis_hold", sout1, 32'h44332211);
    q1.push_back(8'hA0); q1.push_back(8'hA1); q1.push_back(8'hA2); q1.push_back(8'hA3);
    en1 = 1'b1;
    wait_sig(3, 40, n);
    chk("re_fill", 32'(fill1), 32'd1);
    wait_sig(0, 3200, n);
    chk("re_strobe", 32'(str1), 32'd1);
    chk("re_sample", sout1, 32'hA3A2A1A0);
    wait_sig(2, 3200, n);
    chk("re_underrun", 32'(ur1), 32'd1);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sample1", sout1, 32'h0);
    chk("arst_underrun", 32'(ur1), 32'd0);
    chk("arst_sample2", 32'(sout2), 32'h0);
    chk("arst_req", 32'(bus1.byte_req), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sig(4, 2, n);
    chk("rel_req", 32'(bus1.byte_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
